bus_dma_master: RTL

Bus initiator that drives the data-bus request side (read/write strobe, address, write data) and consumes the responder's read data and done flag. It copies Length 16-bit words from SrcAddr to DstAddr as alternating single-word read and write transactions. The CPU configures and starts it through a small control port. It sits beside the CPU as a second requester in front of the data-bus arbiter, which is outside this block.

---
 rtl/bus_pkg.sv | 27 ++
 rtl/bus_dma_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for data-bus requesters. It holds the device-select
// codes, the default bus widths and the DMA master state encoding.
// ---------------------------------------------------------------------------
package bus_pkg;

  // Device-select codes decoded by the data-bus fabric.
  localparam logic [3:0] DEV_MEM    = 4'h0;
  localparam logic [3:0] DEV_ONCHIP = 4'h1;
  localparam logic [3:0] DEV_IO     = 4'h2;

  // Default bus widths.
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;

  // DMA master sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_GAP,
    WR_REQ,
    WR_GAP,
    FIN
  } dma_state_t;

endpackage

// File: rtl/bus_dma_master.sv
// ---------------------------------------------------------------------------
// bus_dma_master
// Bus initiator that copies Length words from SrcAddr to DstAddr. Each word
// is moved as one single-word read followed by one single-word write, and
// every request is followed by one idle bus cycle.
//
// Ports
//   Clock, Reset     : clock (rising edge), asynchronous active-low reset
//   Start            : one-cycle pulse; latches SrcAddr/DstAddr/Length in IDLE
//   SrcAddr, DstAddr : first source / destination word address
//   Length           : number of words to copy (0 gives an empty transfer)
//   Abort            : finish the current word, then stop
//   Busy             : high from the cycle after an accepted Start until Done
//   Done             : one-cycle completion pulse
//   Aborted          : sticky stop-by-abort/timeout flag, cleared by Start
//   DmaRead/DmaWrite : registered request strobes, never high together
//   DmaAddr          : request address
//   DmaWrData        : write data, valid with DmaWrite
//   DmaRdData        : responder read data, valid with DmaDone on a read
//   DmaDone          : responder completion, combinational or registered
//
// Optional build macro
//   DMA_TIMEOUT_EN   : adds a per-request wait counter. A request that sees
//                      no DmaDone for TIMEOUT_CYCLES cycles is dropped, the
//                      transfer ends and Aborted is set.
// ---------------------------------------------------------------------------
module bus_dma_master
  import bus_pkg::*;
#(
  parameter int ADDR_W         = BUS_ADDR_W,
  parameter int DATA_W         = BUS_DATA_W,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [LEN_W-1:0]  Length,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic              Aborted,
  output logic              DmaRead,
  output logic              DmaWrite,
  output logic [ADDR_W-1:0] DmaAddr,
  output logic [DATA_W-1:0] DmaWrData,
  input  logic [DATA_W-1:0] DmaRdData,
  input  logic              DmaDone
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  dma_state_t        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              abort_pend_q, abort_pend_d;
  logic              aborted_q, aborted_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;

`ifdef DMA_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  // Next-state and next-output logic. Bus outputs are derived from the next
  // state so the strobes come straight from flops and rise in the first
  // cycle of a request state.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    data_d    = data_q;
    aborted_d = aborted_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    // Abort is remembered from any active state until the word finishes.
    abort_pend_d = abort_pend_q | (Abort && (state_q != IDLE));
`ifdef DMA_TIMEOUT_EN
    wait_d = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          aborted_d    = 1'b0;
          busy_d       = 1'b1;
          abort_pend_d = 1'b0;
          if (Length != '0) begin
            src_d   = SrcAddr;
            dst_d   = DstAddr;
            rem_d   = Length;
            state_d = RD_REQ;
          end else begin
            state_d = FIN;
          end
        end
      end

      RD_REQ: begin
        if (DmaDone) begin
          data_d  = DmaRdData;
          state_d = RD_GAP;
        end
`ifdef DMA_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          aborted_d = 1'b1;
          state_d   = FIN;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end

      // The responder's done flag toggles while a request is held, so the
      // strobe must be low for a cycle before the next request.
      RD_GAP: state_d = WR_REQ;

      WR_REQ: begin
        if (DmaDone) begin
          src_d   = src_q + 1'b1;
          dst_d   = dst_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = WR_GAP;
        end
`ifdef DMA_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          aborted_d = 1'b1;
          state_d   = FIN;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end

      // Word boundary: the only place an abort can stop the copy.
      WR_GAP: begin
        if ((rem_q == '0) || abort_pend_d) begin
          if (abort_pend_d && (rem_q != '0)) begin
            aborted_d = 1'b1;
          end
          state_d = FIN;
        end else begin
          state_d = RD_REQ;
        end
      end

      // Done is registered, so it pulses in the cycle after FIN together
      // with the Busy drop.
      FIN: begin
        done_d       = 1'b1;
        busy_d       = 1'b0;
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    rd_d   = (state_d == RD_REQ);
    wr_d   = (state_d == WR_REQ);
    addr_d = '0;
    wdat_d = '0;
    if (rd_d) begin
      addr_d = src_d;
    end else if (wr_d) begin
      addr_d = dst_d;
      wdat_d = data_d;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      data_q       <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdat_q       <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      data_q       <= data_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdat_q       <= wdat_d;
    end
  end

`ifdef DMA_TIMEOUT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Aborted   = aborted_q;
  assign DmaRead   = rd_q;
  assign DmaWrite  = wr_q;
  assign DmaAddr   = addr_q;
  assign DmaWrData = wdat_q;

endmodule
